// File: rtl/bus_fifo_packer_pkg.sv
// Shared constants and types for the byte-to-word FIFO packer.
// Lane index selects one byte of the 32-bit assembly word.
package bus_fifo_packer_pkg;

   localparam logic [7:0] PAD_DEFAULT  = 8'hFF;
   localparam int         CNTW_DEFAULT = 16;
   localparam int         LANES        = 4;

   typedef logic [1:0] lane_t;

   localparam lane_t LAST_LANE = 2'd3;

endpackage

// File: rtl/bus_fifo_packer_if.sv
// Byte-stream, FIFO-write and event-report signals of the packer.
// The slave modport is the packer itself; the master is its environment.
interface bus_fifo_packer_if
   import bus_fifo_packer_pkg::*;
#(
   parameter int CNTW = CNTW_DEFAULT
);

   logic [7:0]      data_i;
   logic            valid_i;
   logic            last_i;
   logic            ready_o;
   logic [31:0]     fifo_data_o;
   logic            fifo_we_o;
   logic            fifo_full_i;
   logic            evt_done_o;
   logic [CNTW-1:0] evt_words_o;

   modport master (
      output data_i, valid_i, last_i, fifo_full_i,
      input  ready_o, fifo_data_o, fifo_we_o, evt_done_o, evt_words_o
   );

   modport slave (
      input  data_i, valid_i, last_i, fifo_full_i,
      output ready_o, fifo_data_o, fifo_we_o, evt_done_o, evt_words_o
   );

endinterface

// File: rtl/bus_fifo_packer_skid.sv
// One-word pending register in front of a FIFO that does no overflow checking.
// A reload in the write cycle keeps the slot occupied without a bubble.
module bus_fifo_packer_skid (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] word_i,
   input  logic        last_i,
   input  logic        fifo_full_i,
   output logic        pend_v_o,
   output logic        pend_last_o,
   output logic        we_o,
   output logic [31:0] word_o
);

   logic [31:0] pend_q, pend_d;
   logic        pend_v_q, pend_v_d;
   logic        pend_last_q, pend_last_d;

   // Suppressed during reset so a discarded pending word never reaches the FIFO.
   assign we_o        = pend_v_q & ~fifo_full_i & ~rst_i;
   assign pend_v_o    = pend_v_q;
   assign pend_last_o = pend_last_q;
   assign word_o      = pend_q;

   always_comb begin
      pend_d      = pend_q;
      pend_v_d    = pend_v_q;
      pend_last_d = pend_last_q;
      if (load_i) begin
         pend_d      = word_i;
         pend_v_d    = 1'b1;
         pend_last_d = last_i;
      end else if (we_o) begin
         pend_v_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q      <= '0;
         pend_v_q    <= 1'b0;
         pend_last_q <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         pend_v_q    <= pend_v_d;
         pend_last_q <= pend_last_d;
      end
   end

endmodule

// File: rtl/bus_fifo_packer.sv
// Packs an 8-bit byte stream little-endian into 32-bit FIFO words, pads the
// final partial word of each event, and reports the word count per event.
module bus_fifo_packer
   import bus_fifo_packer_pkg::*;
#(
   parameter logic [7:0] PAD  = PAD_DEFAULT,
   parameter int         CNTW = CNTW_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   bus_fifo_packer_if.slave  bus
);

   logic [31:0]     asm_q, asm_d;
   lane_t           cnt_q, cnt_d;
   logic [CNTW-1:0] wcnt_q, wcnt_d;
   logic [CNTW-1:0] evt_words_q, evt_words_d;
   logic [CNTW-1:0] wcnt_inc;

   logic [31:0]     word_merge;
   logic [31:0]     word_fill;
   logic [31:0]     pend_word;
   logic            pend_v;
   logic            pend_last;
   logic            ready;
   logic            acc;
   logic            complete;
   logic            we;
   logic            evt_done;

   assign ready    = ~(pend_v & bus.fifo_full_i);
   assign acc      = bus.valid_i & ready;
   assign complete = acc & ((cnt_q == LAST_LANE) | bus.last_i);

   // word_merge writes the incoming byte into its lane; word_fill also pads
   // the lanes above it for a word leaving the assembly register.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         localparam lane_t LANE = lane_t'(gi);
         assign word_merge[gi*8 +: 8] = (cnt_q == LANE) ? bus.data_i : asm_q[gi*8 +: 8];
         assign word_fill[gi*8 +: 8]  = (LANE > cnt_q)  ? PAD         : word_merge[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      asm_d = asm_q;
      cnt_d = cnt_q;
      if (complete) begin
         asm_d = '0;
         cnt_d = '0;
      end else if (acc) begin
         asm_d = word_merge;
         cnt_d = lane_t'(cnt_q + 2'd1);
      end
   end

   bus_fifo_packer_skid u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (complete),
      .word_i      (word_fill),
      .last_i      (bus.last_i),
      .fifo_full_i (bus.fifo_full_i),
      .pend_v_o    (pend_v),
      .pend_last_o (pend_last),
      .we_o        (we),
      .word_o      (pend_word)
   );

   assign wcnt_inc = (&wcnt_q) ? wcnt_q : wcnt_q + CNTW'(1);
   assign evt_done = we & pend_last;

   always_comb begin
      wcnt_d      = wcnt_q;
      evt_words_d = evt_words_q;
      if (we) begin
         if (pend_last) begin
            wcnt_d      = '0;
            evt_words_d = wcnt_inc;
         end else begin
            wcnt_d      = wcnt_inc;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         asm_q       <= '0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         evt_words_q <= '0;
      end else begin
         asm_q       <= asm_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         evt_words_q <= evt_words_d;
      end
   end

   // The count is visible in the completion cycle itself, then held.
   assign bus.ready_o     = ready;
   assign bus.fifo_we_o   = we;
   assign bus.fifo_data_o = pend_word;
   assign bus.evt_done_o  = evt_done;
   assign bus.evt_words_o = evt_done ? wcnt_inc : evt_words_q;

endmodule

// File: tb/tb_bus_fifo_packer.sv
// Self-checking bench for bus_fifo_packer: directed vector table, hand-written
// stall/reset/burst sequences, and randomized events against a word-level model.
module tb_bus_fifo_packer;
   import bus_fifo_packer_pkg::*;

   localparam time PERIOD = 10;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bus_fifo_packer_if #(.CNTW(16)) bus ();

   bus_fifo_packer #(.PAD(8'hFF), .CNTW(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   logic [31:0] cap_word [$];
   logic        cap_done [$];
   logic [15:0] cap_cnt  [$];
   time         cap_time [$];

   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (bus.fifo_we_o !== 1'b0) begin
            errors++;
            $display("FAIL we_in_reset actual=%b required=0", bus.fifo_we_o);
         end
      end else if (bus.fifo_we_o === 1'b1) begin
         checks++;
         if (bus.fifo_full_i) begin
            errors++;
            $display("FAIL we_while_full actual=1 required=0 at %0t", $time);
         end
         cap_word.push_back(bus.fifo_data_o);
         cap_done.push_back(bus.evt_done_o);
         cap_cnt.push_back(bus.evt_words_o);
         cap_time.push_back($time);
      end else if (bus.evt_done_o === 1'b1) begin
         errors++;
         $display("FAIL done_without_write actual=1 required=0 at %0t", $time);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_cap();
      cap_word.delete();
      cap_done.delete();
      cap_cnt.delete();
      cap_time.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      bus.valid_i = 1'b0;
      bus.last_i  = 1'b0;
      bus.data_i  = 8'h00;
   endtask

   // Called #1 after a rising edge; returns the time of the accepting negedge.
   task automatic send_byte(input logic [7:0] b, input logic l, output time t_acc);
      int   guard;
      logic got;
      bus.data_i  = b;
      bus.valid_i = 1'b1;
      bus.last_i  = l;
      got   = 1'b0;
      guard = 0;
      t_acc = 0;
      while (!got && guard < 200) begin
         @(negedge clk);
         got = bus.ready_o;
         if (got) t_acc = $time;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=stalled required=accepted byte=%0h", b);
      end
   endtask

   typedef struct {
      logic [7:0]  bytes [8];
      int          nbytes;
      logic [31:0] words [2];
      int          nwords;
   } vec_t;

   vec_t vecs [5];

   logic [31:0] exp_word [$];
   logic        exp_done [$];
   logic [15:0] exp_cnt  [$];
   logic        stop_rand;

   initial begin
      #1ms;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      time t;
      time t_last;
      int  bad;
      int  ndone;
      int  stalls;

      checks    = 0;
      errors    = 0;
      stop_rand = 1'b0;
      rst       = 1'b1;
      bus.fifo_full_i = 1'b0;
      idle();

      vecs[0].bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[0].nbytes = 4; vecs[0].words = '{32'h44332211, 32'h0}; vecs[0].nwords = 1;
      vecs[1].bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
      vecs[1].nbytes = 6; vecs[1].words = '{32'h04030201, 32'hFFFF0605}; vecs[1].nwords = 2;
      vecs[2].bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2].nbytes = 1; vecs[2].words = '{32'hFFFFFFA5, 32'h0}; vecs[2].nwords = 1;
      vecs[3].bytes = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[3].nbytes = 3; vecs[3].words = '{32'hFFCCBBAA, 32'h0}; vecs[3].nwords = 1;
      vecs[4].bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
      vecs[4].nbytes = 8; vecs[4].words = '{32'h40302010, 32'h80706050}; vecs[4].nwords = 2;

      wait_cycles(3);
      @(negedge clk);
      chk("reset_ready", bus.ready_o, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_we", bus.fifo_we_o, 1'b0);
      chk("reset_done", bus.evt_done_o, 1'b0);
      chk("reset_evt_words", bus.evt_words_o, 16'd0);
      chk("reset_data", bus.fifo_data_o, 32'd0);
      @(posedge clk);
      #1;

      // Directed vector table.
      for (int i = 0; i < 5; i++) begin
         clear_cap();
         t_last = 0;
         for (int j = 0; j < vecs[i].nbytes; j++) begin
            send_byte(vecs[i].bytes[j], (j == vecs[i].nbytes - 1), t);
            t_last = t;
         end
         idle();
         wait_cycles(3);
         chk($sformatf("vec%0d_nwords", i), cap_word.size(), vecs[i].nwords);
         if (cap_word.size() == vecs[i].nwords) begin
            for (int k = 0; k < vecs[i].nwords; k++) begin
               chk($sformatf("vec%0d_word%0d", i, k), cap_word[k], vecs[i].words[k]);
               chk($sformatf("vec%0d_done%0d", i, k), cap_done[k], (k == vecs[i].nwords - 1));
            end
            chk($sformatf("vec%0d_evt_words", i), cap_cnt[vecs[i].nwords-1], vecs[i].nwords);
            chk($sformatf("vec%0d_latency", i), cap_time[vecs[i].nwords-1], t_last + PERIOD);
         end
         chk($sformatf("vec%0d_evt_hold", i), bus.evt_words_o, vecs[i].nwords);
      end

      // FIFO full while streaming 8 bytes; release after 5 stalled cycles.
      clear_cap();
      bus.fifo_full_i = 1'b1;
      for (int j = 0; j < 4; j++) send_byte(8'(j + 1), 1'b0, t);
      bus.data_i  = 8'h05;
      bus.valid_i = 1'b1;
      bus.last_i  = 1'b0;
      stalls = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.ready_o === 1'b0) stalls++;
         @(posedge clk);
         #1;
      end
      chk("full_stall_cycles", stalls, 5);
      chk("full_no_write", cap_word.size(), 0);
      bus.fifo_full_i = 1'b0;
      for (int j = 4; j < 8; j++) send_byte(8'(j + 1), (j == 7), t);
      idle();
      wait_cycles(3);
      chk("full_nwords", cap_word.size(), 2);
      if (cap_word.size() == 2) begin
         chk("full_word0", cap_word[0], 32'h04030201);
         chk("full_word1", cap_word[1], 32'h08070605);
         chk("full_evt_words", cap_cnt[1], 16'd2);
      end

      // Reset with a pending word and with a half-built word.
      clear_cap();
      bus.fifo_full_i = 1'b1;
      for (int j = 0; j < 4; j++) send_byte(8'hE0 + 8'(j), 1'b0, t);
      idle();
      rst = 1'b1;
      bus.fifo_full_i = 1'b0;
      wait_cycles(1);
      rst = 1'b0;
      wait_cycles(2);
      chk("rst_pending_dropped", cap_word.size(), 0);
      send_byte(8'h11, 1'b0, t);
      send_byte(8'h22, 1'b0, t);
      idle();
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      send_byte(8'h11, 1'b0, t);
      send_byte(8'h22, 1'b0, t);
      send_byte(8'h33, 1'b0, t);
      send_byte(8'h44, 1'b1, t);
      idle();
      wait_cycles(3);
      chk("rst_nwords", cap_word.size(), 1);
      if (cap_word.size() == 1) begin
         chk("rst_word", cap_word[0], 32'h44332211);
         chk("rst_evt_words", cap_cnt[0], 16'd1);
      end

      // 4000-byte back-to-back event.
      clear_cap();
      for (int j = 0; j < 4000; j++) send_byte(8'(j), (j == 3999), t);
      idle();
      wait_cycles(3);
      chk("burst_nwords", cap_word.size(), 1000);
      bad   = 0;
      ndone = 0;
      for (int k = 0; k < cap_word.size(); k++) begin
         if (k > 0 && cap_time[k] - cap_time[k-1] != 4 * PERIOD) bad++;
         if (cap_done[k]) ndone++;
         if (cap_word[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
      end
      chk("burst_spacing_and_data", bad, 0);
      chk("burst_ndone", ndone, 1);
      if (cap_word.size() == 1000) begin
         chk("burst_last_done", cap_done[999], 1'b1);
         chk("burst_evt_words", cap_cnt[999], 16'd1000);
      end

      // Randomized events with random gaps, stray last_i and FIFO-full toggling.
      clear_cap();
      exp_word.delete();
      exp_done.delete();
      exp_cnt.delete();
      fork
         begin
            while (!stop_rand) begin
               @(posedge clk);
               #2;
               bus.fifo_full_i = ($urandom_range(0, 9) < 4);
            end
         end
      join_none
      for (int e = 0; e < 60; e++) begin
         int         len;
         logic [7:0] evb [$];
         len = $urandom_range(1, 10);
         evb.delete();
         for (int j = 0; j < len; j++) evb.push_back(8'($urandom));
         for (int k = 0; k < len; k += 4) begin
            logic [31:0] w;
            w = 32'hFFFFFFFF;
            for (int l = 0; l < 4; l++)
               if (k + l < len) w[l*8 +: 8] = evb[k+l];
            exp_word.push_back(w);
            exp_done.push_back(k + 4 >= len);
            exp_cnt.push_back(16'((len + 3) / 4));
         end
         for (int j = 0; j < len; j++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               bus.valid_i = 1'b0;
               bus.last_i  = 1'($urandom_range(0, 1));
               bus.data_i  = 8'($urandom);
               wait_cycles(1);
            end
            send_byte(evb[j], (j == len - 1), t);
         end
      end
      idle();
      stop_rand = 1'b1;
      wait_cycles(2);
      bus.fifo_full_i = 1'b0;
      wait_cycles(4);
      chk("rand_nwords", cap_word.size(), exp_word.size());
      bad = 0;
      for (int k = 0; k < exp_word.size() && k < cap_word.size(); k++) begin
         if (cap_word[k] !== exp_word[k] || cap_done[k] !== exp_done[k] ||
             (exp_done[k] && cap_cnt[k] !== exp_cnt[k])) begin
            bad++;
            if (bad <= 5)
               $display("FAIL rand_word%0d actual=%h/%b/%0d required=%h/%b/%0d", k,
                        cap_word[k], cap_done[k], cap_cnt[k],
                        exp_word[k], exp_done[k], exp_cnt[k]);
         end
      end
      checks++;
      if (bad != 0) errors++;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
